spi_shift_engine: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0) serializer, downstream of the OBI register front-end.

---
 rtl/spi_shift_engine_if.sv | 26 ++
 rtl/spi_shift_engine.sv | 162 ++++++++++++++++
 tb/tb_spi_shift_engine.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_if.sv
// Command / response handshake bundle between the register front-end and the
// SPI shift engine. Signal suffixes are from the engine's point of view.
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int LEN_W = $clog2(DATA_WIDTH);

    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic [LEN_W-1:0]      tx_len_i;
    logic                  tx_last_i;
    logic                  rx_valid_o;
    logic                  rx_ready_i;
    logic [DATA_WIDTH-1:0] rx_data_o;

    modport slave (
        input  tx_valid_i, tx_data_i, tx_len_i, tx_last_i, rx_ready_i,
        output tx_ready_o, rx_valid_o, rx_data_o
    );

    modport master (
        output tx_valid_i, tx_data_i, tx_len_i, tx_last_i, rx_ready_i,
        input  tx_ready_o, rx_valid_o, rx_data_o
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 serializer: one word per command, MSB first, MISO sampled on the
// SCLK rising edge, SS optionally held low between words of a frame.
module spi_shift_engine #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKDIV_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CLKDIV_WIDTH-1:0] clkdiv_i,
    spi_shift_engine_if.slave       bus,
    output logic                    busy_o,
    output logic                    spi_ss_o,
    output logic                    spi_sclk_o,
    output logic                    spi_mosi_o,
    input  logic                    spi_miso_i
);
    localparam int LEN_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, HOLD, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CLKDIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [CLKDIV_WIDTH-1:0] div_q, div_d;
    logic [LEN_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    ss_q, ss_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;

    logic tx_ready;
    logic accept;
    logic phase_done;

    // A new word may only start once the previous response has been taken.
    assign tx_ready   = ((state_q == IDLE) || (state_q == HOLD)) && !rx_valid_q;
    assign accept     = bus.tx_valid_i && tx_ready;
    // Every timed phase lasts D+1 clocks, using the divider latched at accept.
    assign phase_done = (cnt_q == div_q);

    assign bus.tx_ready_o = tx_ready;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.rx_data_o  = rx_data_q;
    assign busy_o         = (state_q != IDLE);
    assign spi_ss_o       = ss_q;
    assign spi_sclk_o     = sclk_q;
    assign spi_mosi_o     = mosi_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, HOLD: if (accept)     state_d = LOW;
            LOW:        if (phase_done) state_d = HIGH;
            HIGH:       if (phase_done) state_d = (bit_q != '0) ? LOW : TAIL;
            TAIL:       if (phase_done) state_d = last_q ? GAP : HOLD;
            GAP:        if (phase_done) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Output / datapath next values; SPI pins are registered from these.
    always_comb begin
        cnt_d      = '0;
        div_d      = div_q;
        bit_d      = bit_q;
        data_d     = data_q;
        last_d     = last_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;

        if (rx_valid_q && bus.rx_ready_i) rx_valid_d = 1'b0;

        unique case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    data_d  = bus.tx_data_i;
                    bit_d   = bus.tx_len_i;
                    last_d  = bus.tx_last_i;
                    div_d   = clkdiv_i;
                    rx_sh_d = '0;
                    ss_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = bus.tx_data_i[bus.tx_len_i];
                end
            end
            LOW: begin
                cnt_d = phase_done ? '0 : cnt_q + CLKDIV_WIDTH'(1);
                if (phase_done) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], spi_miso_i};
                end
            end
            HIGH: begin
                cnt_d = phase_done ? '0 : cnt_q + CLKDIV_WIDTH'(1);
                if (phase_done) begin
                    sclk_d = 1'b0;
                    if (bit_q != '0) begin
                        bit_d  = bit_q - LEN_W'(1);
                        mosi_d = data_q[bit_q - LEN_W'(1)];
                    end
                end
            end
            TAIL: begin
                cnt_d = phase_done ? '0 : cnt_q + CLKDIV_WIDTH'(1);
                if (phase_done) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    if (last_q) begin
                        ss_d   = 1'b1;
                        mosi_d = 1'b0;
                    end
                end
            end
            GAP: begin
                cnt_d = phase_done ? '0 : cnt_q + CLKDIV_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // Control and pin registers; reset aborts any transfer on the next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    // Word data registers; only meaningful after an accept reloads them.
    always_ff @(posedge clk_i) begin
        div_q   <= div_d;
        bit_q   <= bit_d;
        data_q  <= data_d;
        last_q  <= last_d;
        rx_sh_q <= rx_sh_d;
    end
endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: expected rx words are queued at
// command time and compared as the engine hands them out.
module tb_spi_shift_engine;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] clkdiv_i = 16'd0;
    logic        busy_o, spi_ss_o, spi_sclk_o, spi_mosi_o, spi_miso_i;

    spi_shift_engine_if #(.DATA_WIDTH(32)) bus ();

    spi_shift_engine #(.DATA_WIDTH(32), .CLKDIV_WIDTH(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clkdiv_i   (clkdiv_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .spi_ss_o   (spi_ss_o),
        .spi_sclk_o (spi_sclk_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter and scoreboard state
    int          cyc = 0;
    logic [63:0] sb[$];
    int          acc_cyc = 0;
    int          rise_cyc = 0;
    int          hs_cyc = 0;
    logic        prev_rxv = 1'b0;
    int          hi_run = 0;
    int          last_hi = 0;

    // MISO model: loopback of MOSI, or a fixed pattern sent MSB first
    logic        pat_mode = 1'b0;
    logic [31:0] pat = 32'h0F0F_0F0F;
    int          cur_len = 0;
    int          word_base = 0;
    int          rises_total = 0;
    int          frame_base = 0;
    logic [31:0] mosi_sh = '0;
    logic [4:0]  miso_idx;

    assign miso_idx   = 5'(cur_len - (rises_total - word_base));
    assign spi_miso_i = pat_mode ? pat[miso_idx] : spi_mosi_o;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge spi_sclk_o) begin
        rises_total = rises_total + 1;
        mosi_sh     = {mosi_sh[30:0], spi_mosi_o};
    end

    always @(negedge spi_ss_o) frame_base = rises_total;

    // Response monitor: pops the scoreboard on every rx handshake
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_rxv = 1'b0;
            hi_run   = 0;
        end else begin
            if (bus.rx_valid_o && !prev_rxv) rise_cyc = cyc;
            if (bus.rx_valid_o && bus.rx_ready_i) begin
                hs_cyc = cyc;
                if (sb.size() == 0) chk_eq("rx_unexpected", bus.rx_valid_o, 0);
                else                chk_eq("rx_data", bus.rx_data_o, sb.pop_front());
            end
            prev_rxv = bus.rx_valid_o;
            if (spi_sclk_o) hi_run++;
            else if (hi_run != 0) begin
                last_hi = hi_run;
                hi_run  = 0;
            end
        end
    end

    task automatic send(input logic [31:0] data, input int len, input logic last,
                        input logic [15:0] div, input int hold);
        int          n;
        int          cnt;
        logic [63:0] mask;
        @(posedge clk_i); #1;
        bus.tx_data_i  = data;
        bus.tx_len_i   = 5'(len);
        bus.tx_last_i  = last;
        bus.tx_valid_i = 1'b1;
        clkdiv_i       = div;
        cur_len        = len;
        word_base      = rises_total;
        if (hold > 0) begin
            cnt = 0;
            repeat (hold) begin
                @(negedge clk_i);
                if (bus.tx_ready_o) cnt++;
            end
            chk_eq("hold_tx_ready", cnt, 0);
            @(posedge clk_i); #1;
            bus.rx_ready_i = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.tx_ready_o && n < 5000);
        chk_eq("tx_accept", bus.tx_ready_o, 1);
        acc_cyc = cyc + 1;
        mask = (64'd1 << (len + 1)) - 64'd1;
        sb.push_back(pat_mode ? ({32'd0, pat} & mask) : ({32'd0, data} & mask));
        @(posedge clk_i); #1;
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy_o) && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        chk_eq("wait_idle", (sb.size() == 0) && !busy_o, 1);
    endtask

    task automatic wait_rx_valid();
        int n = 0;
        while (!bus.rx_valid_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        chk_eq("wait_rx_valid", bus.rx_valid_o, 1);
    endtask

    initial begin
        int n;
        int cnt;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = '0;
        bus.tx_len_i   = '0;
        bus.tx_last_i  = 1'b0;
        bus.rx_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_eq("rst_ss",       spi_ss_o, 1);
        chk_eq("rst_sclk",     spi_sclk_o, 0);
        chk_eq("rst_mosi",     spi_mosi_o, 0);
        chk_eq("rst_rx_valid", bus.rx_valid_o, 0);
        chk_eq("rst_rx_data",  bus.rx_data_o, 0);
        chk_eq("rst_busy",     busy_o, 0);
        chk_eq("rst_tx_ready", bus.tx_ready_o, 1);

        // D=1, 8-bit loopback word closing the frame
        send(32'hA5, 7, 1'b1, 16'd1, 0);
        wait_rx_valid();
        cnt = 0;
        n   = 0;
        while (!bus.tx_ready_o && n < 100) begin
            if (spi_ss_o) cnt++;
            @(negedge clk_i);
            n++;
        end
        chk_eq("ss_gap_min2", cnt >= 2, 1);
        wait_idle();
        chk_eq("lat_d1_len7", rise_cyc - acc_cyc, 34);
        chk_eq("sclk_rises_a5", rises_total - frame_base, 8);
        chk_eq("sclk_high_d1", last_hi, 2);

        // D=0, two words in one SS frame
        send(32'h12, 7, 1'b0, 16'd0, 0);
        send(32'h34, 7, 1'b1, 16'd0, 0);
        wait_idle();
        chk_eq("frame_rises_16", rises_total - frame_base, 16);
        chk_eq("lat_d0_len7", rise_cyc - acc_cyc, 17);

        // Full word out, patterned MISO in
        pat_mode = 1'b1;
        send(32'hDEAD_BEEF, 31, 1'b1, 16'd0, 0);
        wait_idle();
        chk_eq("mosi_msb_first", mosi_sh, 32'hDEAD_BEEF);
        chk_eq("sclk_rises_32", rises_total - frame_base, 32);
        pat_mode = 1'b0;

        // Response held back in HOLD blocks the next command
        @(posedge clk_i); #1;
        bus.rx_ready_i = 1'b0;
        send(32'h5A, 7, 1'b0, 16'd0, 0);
        wait_rx_valid();
        send(32'h3C, 3, 1'b1, 16'd0, 20);
        chk_eq("accept_after_pop", acc_cyc - hs_cyc, 2);
        wait_idle();

        // Reset during a D=3 transfer
        send(32'hC3, 7, 1'b1, 16'd3, 0);
        n = 0;
        while ((rises_total - frame_base) < 4 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        chk_eq("rst_mid_reached", (rises_total - frame_base) >= 4, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb.delete();
        @(negedge clk_i);
        chk_eq("abort_ss",       spi_ss_o, 1);
        chk_eq("abort_sclk",     spi_sclk_o, 0);
        chk_eq("abort_rx_valid", bus.rx_valid_o, 0);
        chk_eq("abort_busy",     busy_o, 0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (bus.rx_valid_o || busy_o) cnt++;
        end
        chk_eq("abort_no_rx", cnt, 0);

        // Divider change mid-word only affects the following word
        send(32'h96, 7, 1'b1, 16'd1, 0);
        n = 0;
        while ((rises_total - frame_base) < 2 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i); #1;
        clkdiv_i = 16'd5;
        wait_idle();
        chk_eq("div_keep_high", last_hi, 2);
        chk_eq("div_keep_lat", rise_cyc - acc_cyc, 34);
        send(32'h69, 7, 1'b1, 16'd5, 0);
        wait_idle();
        chk_eq("div_new_high", last_hi, 6);
        chk_eq("div_new_lat", rise_cyc - acc_cyc, 102);

        repeat (5) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
